// File: rtl/vector_frame_buffer.sv
// ---------------------------------------------------------------------------
// vector_frame_buffer
//
// Double-buffered display-list store sitting directly upstream of draw_line.
// A producer fills the back bank one point at a time and then commits it.
// The block keeps replaying the front bank to draw_line, frame after frame,
// with one {x, y, blank} point per strobe/ready handshake. The banks swap
// only at a frame boundary, or promptly when nothing is playing, so the beam
// never traces a half-written frame.
//
// Parameters
//   ADDR_W        address width per bank; each bank holds 2**ADDR_W points
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high
//   wr_en         write one point into the back bank this cycle
//   wr_x, wr_y    point coordinates (12 bit)
//   wr_blank      1 = move to this point with the beam off
//   commit        one-cycle pulse: back bank complete, request a swap
//   wr_full       back bank holds 2**ADDR_W points
//   wr_overflow   sticky until the next swap: a write was dropped while full
//   swap_pending  commit accepted, swap not yet done
//   x, y, blank   current point presented to draw_line
//   strobe        one-cycle pulse: x/y/blank valid, draw to it
//   ready         draw_line can take the next point
//   frame_done    one-cycle pulse after the last point of a frame is strobed
// ---------------------------------------------------------------------------
module vector_frame_buffer #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [11:0] wr_x,
    input  logic [11:0] wr_y,
    input  logic        wr_blank,
    input  logic        commit,
    output logic        wr_full,
    output logic        wr_overflow,
    output logic        swap_pending,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        blank,
    output logic        strobe,
    input  logic        ready,
    output logic        frame_done
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam int unsigned COORD_W = 12;
    localparam int unsigned BANK_W  = ADDR_W + 1;

    // One stored display-list entry.
    typedef struct packed {
        logic               blank;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        GAP
    } state_t;

    // Both banks share one array; the top address bit selects the bank.
    point_t mem [2*DEPTH];
    point_t rd_data;

    state_t             state;
    logic               front_sel;
    logic [CNT_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   back_count;
    logic [CNT_W-1:0]   front_count;
    logic [CNT_W-1:0]   rd_ptr;

    logic               wr_accept_c;
    logic               commit_take_c;
    logic               last_point_c;
    logic               do_swap_c;
    logic [CNT_W-1:0]   next_front_count_c;
    logic [BANK_W-1:0]  wr_addr_c;
    logic [BANK_W-1:0]  rd_addr_c;

    // Handshake and swap decisions shared by the write side and the reader.
    always_comb begin
        wr_accept_c   = wr_en && !wr_full && !swap_pending;
        commit_take_c = commit && !swap_pending;
        last_point_c  = (rd_ptr == (front_count - CNT_W'(1)));
        // Swap only when the reader is idle or has just finished a frame.
        do_swap_c     = swap_pending &&
                        ((state == IDLE) || ((state == GAP) && last_point_c));
        // Frame length the reader will see after this cycle.
        next_front_count_c = do_swap_c ? back_count : front_count;
        wr_addr_c     = {~front_sel, wr_ptr[ADDR_W-1:0]};
        rd_addr_c     = {front_sel, rd_ptr[ADDR_W-1:0]};
    end

    // Point storage: one write port into the back bank, registered read of
    // the front bank issued from FETCH.
    always_ff @(posedge clk) begin
        if (wr_accept_c) begin
            mem[wr_addr_c] <= '{blank: wr_blank, x: wr_x, y: wr_y};
        end
        if (state == FETCH) begin
            rd_data <= mem[rd_addr_c];
        end
    end

    // Write side: back-bank fill pointer, commit capture and bank swap.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            wr_full      <= 1'b0;
            wr_overflow  <= 1'b0;
            swap_pending <= 1'b0;
            back_count   <= '0;
            front_count  <= '0;
            front_sel    <= 1'b0;
        end else if (do_swap_c) begin
            // swap_pending is set here, so no write or commit can be accepted.
            front_sel    <= ~front_sel;
            front_count  <= back_count;
            wr_ptr       <= '0;
            wr_full      <= 1'b0;
            wr_overflow  <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            if (wr_accept_c) begin
                wr_ptr  <= wr_ptr + CNT_W'(1);
                wr_full <= (wr_ptr == CNT_W'(DEPTH - 1));
            end
            // Drops while a swap is pending are intentional and not flagged.
            if (wr_en && wr_full && !swap_pending) begin
                wr_overflow <= 1'b1;
            end
            if (commit_take_c) begin
                // Include a point accepted in the same cycle as the commit.
                back_count   <= wr_accept_c ? (wr_ptr + CNT_W'(1)) : wr_ptr;
                swap_pending <= 1'b1;
            end
        end
    end

    // Reader: replays the front bank, one point per ready handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            x          <= '0;
            y          <= '0;
            blank      <= 1'b1;
            strobe     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            strobe     <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_swap_c) begin
                        rd_ptr <= '0;
                        if (back_count != '0) begin
                            state <= FETCH;
                        end else begin
                            blank <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    x     <= rd_data.x;
                    y     <= rd_data.y;
                    blank <= rd_data.blank;
                    state <= SEND;
                end
                SEND: begin
                    if (ready) begin
                        strobe <= 1'b1;
                        state  <= GAP;
                    end
                end
                GAP: begin
                    // ready is ignored here so draw_line can drop it.
                    if (last_point_c) begin
                        frame_done <= 1'b1;
                        rd_ptr     <= '0;
                        if (next_front_count_c != '0) begin
                            state <= FETCH;
                        end else begin
                            // Empty frame committed: park with the beam off.
                            state <= IDLE;
                            blank <= 1'b1;
                        end
                    end else begin
                        rd_ptr <= rd_ptr + CNT_W'(1);
                        state  <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_vector_frame_buffer
//
// Directed bench for vector_frame_buffer with ADDR_W = 2 (4 points per bank).
// Expected points are queued as frames are written; every strobe pops one
// entry and compares it with x/y/blank.
// ---------------------------------------------------------------------------
module tb_vector_frame_buffer;

    localparam int unsigned ADDR_W = 2;

    typedef logic [24:0] pt_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [11:0] wr_x = '0;
    logic [11:0] wr_y = '0;
    logic        wr_blank = 1'b0;
    logic        commit = 1'b0;
    logic        ready = 1'b1;
    logic        wr_full;
    logic        wr_overflow;
    logic        swap_pending;
    logic [11:0] x;
    logic [11:0] y;
    logic        blank;
    logic        strobe;
    logic        frame_done;

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  n_strobe = 0;
    int  n_fd = 0;
    int  last_strobe_cyc = -100;
    bit  spacing_en = 1'b0;
    logic prev_strobe = 1'b0;
    pt_t exp_q[$];

    vector_frame_buffer #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_blank     (wr_blank),
        .commit       (commit),
        .wr_full      (wr_full),
        .wr_overflow  (wr_overflow),
        .swap_pending (swap_pending),
        .x            (x),
        .y            (y),
        .blank        (blank),
        .strobe       (strobe),
        .ready        (ready),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    function automatic pt_t mk(input int px, input int py, input bit pb);
        return {pb, 12'(px), 12'(py)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 ns after the edge and score any strobe.
    task automatic tick();
        pt_t want;
        @(posedge clk);
        #1;
        cyc++;
        if (strobe === 1'b1) begin
            n_strobe++;
            check("strobe_width", 32'(prev_strobe), 32'd0);
            if (spacing_en && last_strobe_cyc >= 0) begin
                check("strobe_spacing", 32'(cyc - last_strobe_cyc), 32'd4);
            end
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'(strobe), 32'd0);
            end else begin
                want = exp_q.pop_front();
                check("point", 32'({blank, x, y}), 32'(want));
            end
            last_strobe_cyc = cyc;
        end
        if (frame_done === 1'b1) begin
            n_fd++;
            check("frame_done_pos", 32'(cyc - last_strobe_cyc), 32'd1);
        end
        prev_strobe = strobe;
    endtask

    // Run until every queued point has been strobed, then stop the handshake.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        ready = 1'b0;
        exp_q.delete();
    endtask

    task automatic write_pt(input pt_t p);
        wr_en    = 1'b1;
        wr_blank = p[24];
        wr_x     = p[23:12];
        wr_y     = p[11:0];
        tick();
        wr_en    = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  base_s;
        int  base_fd;
        int  t;
        pt_t a0, a1, a2, b0, b1, q;
        pt_t p[6];

        // ---- reset and idle ------------------------------------------------
        tick();
        tick();
        reset = 1'b0;
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_blank", 32'(blank), 32'd1);
        check("rst_strobe", 32'(strobe), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_wr_full", 32'(wr_full), 32'd0);
        check("rst_wr_overflow", 32'(wr_overflow), 32'd0);
        check("rst_swap_pending", 32'(swap_pending), 32'd0);
        repeat (20) tick();
        check("idle_no_strobe", 32'(n_strobe), 32'd0);
        check("idle_no_fd", 32'(n_fd), 32'd0);
        check("idle_blank", 32'(blank), 32'd1);

        // ---- three-point frame, replayed twice -----------------------------
        a0 = mk(10, 20, 1'b0);
        a1 = mk(30, 40, 1'b1);
        a2 = mk(50, 60, 1'b0);
        write_pt(a0);
        write_pt(a1);
        write_pt(a2);
        check("three_not_full", 32'(wr_full), 32'd0);
        do_commit();
        check("commit_pending", 32'(swap_pending), 32'd1);
        spacing_en = 1'b1;
        exp_q.push_back(a0); exp_q.push_back(a1); exp_q.push_back(a2);
        exp_q.push_back(a0); exp_q.push_back(a1); exp_q.push_back(a2);
        drain(100);
        spacing_en = 1'b0;
        tick();
        check("repeat_strobes", 32'(n_strobe), 32'd6);
        check("repeat_fd", 32'(n_fd), 32'd2);

        // ---- overflow with a 4-entry bank ----------------------------------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ready = 1'b0;
        base_fd = n_fd;
        for (int i = 0; i < 6; i++) begin
            p[i] = mk(100 + i, 200 + i, bit'(i % 2));
            write_pt(p[i]);
            if (i == 2) check("full_after_3", 32'(wr_full), 32'd0);
            if (i == 3) begin
                check("full_after_4", 32'(wr_full), 32'd1);
                check("ovf_after_4", 32'(wr_overflow), 32'd0);
            end
            if (i == 4) check("ovf_after_5", 32'(wr_overflow), 32'd1);
        end
        do_commit();
        check("ovf_commit_pending", 32'(swap_pending), 32'd1);
        tick();
        check("ovf_swap_done", 32'(swap_pending), 32'd0);
        check("ovf_cleared", 32'(wr_overflow), 32'd0);
        check("full_cleared", 32'(wr_full), 32'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(p[i]);
        exp_q.push_back(p[0]);
        ready = 1'b1;
        drain(100);
        tick();
        check("ovf_frame_fd", 32'(n_fd - base_fd), 32'd1);

        // ---- swap while a frame plays --------------------------------------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a0 = mk(1, 2, 1'b0);
        a1 = mk(3, 4, 1'b1);
        a2 = mk(5, 6, 1'b0);
        b0 = mk(7, 8, 1'b1);
        b1 = mk(9, 10, 1'b0);
        write_pt(a0);
        write_pt(a1);
        write_pt(a2);
        do_commit();
        tick();
        check("a_swapped", 32'(swap_pending), 32'd0);
        exp_q.push_back(a0); exp_q.push_back(a1); exp_q.push_back(a2);
        exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b0);
        ready = 1'b1;
        base_s = n_strobe;
        base_fd = n_fd;
        write_pt(b0);
        write_pt(b1);
        t = 0;
        while (n_strobe < base_s + 2 && t < 50) begin
            tick();
            t++;
        end
        check("reach_a_second", 32'(n_strobe - base_s), 32'd2);
        do_commit();
        check("b_pending", 32'(swap_pending), 32'd1);
        t = 0;
        while (swap_pending === 1'b1 && t < 50) begin
            tick();
            t++;
        end
        check("swap_at_boundary", 32'(cyc - last_strobe_cyc), 32'd1);
        check("swap_after_a_third", 32'(n_strobe - base_s), 32'd3);
        drain(100);
        tick();
        check("ab_fd", 32'(n_fd - base_fd), 32'd2);

        // ---- ready held low in SEND ----------------------------------------
        base_s = n_strobe;
        repeat (50) tick();
        check("stall_no_strobe", 32'(n_strobe - base_s), 32'd0);
        check("stall_hold", 32'({blank, x, y}), 32'(b1));
        exp_q.push_back(b1);
        ready = 1'b1;
        drain(20);
        repeat (10) tick();
        check("stall_one_strobe", 32'(n_strobe - base_s), 32'd1);

        // ---- reset between two strobes -------------------------------------
        exp_q.push_back(b0);
        ready = 1'b1;
        drain(20);
        reset = 1'b1;
        tick();
        check("mid_rst_x", 32'(x), 32'd0);
        check("mid_rst_y", 32'(y), 32'd0);
        check("mid_rst_blank", 32'(blank), 32'd1);
        check("mid_rst_strobe", 32'(strobe), 32'd0);
        check("mid_rst_pending", 32'(swap_pending), 32'd0);
        reset = 1'b0;
        ready = 1'b1;
        base_s = n_strobe;
        repeat (30) tick();
        check("mid_rst_no_strobe", 32'(n_strobe - base_s), 32'd0);

        // ---- single-point frame --------------------------------------------
        q = mk(77, 88, 1'b0);
        write_pt(q);
        do_commit();
        base_fd = n_fd;
        spacing_en = 1'b1;
        last_strobe_cyc = -100;
        exp_q.push_back(q); exp_q.push_back(q); exp_q.push_back(q);
        drain(50);
        spacing_en = 1'b0;
        tick();
        check("single_fd", 32'(n_fd - base_fd), 32'd3);

        // ---- empty frame commit blanks the output --------------------------
        do_commit();
        check("empty_pending", 32'(swap_pending), 32'd1);
        exp_q.push_back(q);
        ready = 1'b1;
        drain(20);
        tick();
        check("empty_swapped", 32'(swap_pending), 32'd0);
        ready = 1'b1;
        base_s = n_strobe;
        repeat (20) tick();
        check("empty_no_strobe", 32'(n_strobe - base_s), 32'd0);
        check("empty_blank", 32'(blank), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
